// File: rtl/noc_params.sv
`default_nettype none
// ============================================================================
//  Module   : noc_params (package)
//  Brief    : Packet format, link framing constants and link FSM states
//             shared by the link framer and its receiver.
//  Revision : 1.0
// ============================================================================
package noc_params;

    localparam int PAYLOAD_SIZE = 8;
    localparam int COORD_W      = 4;

    typedef struct packed {
        logic [COORD_W-1:0]      y_dest;
        logic [COORD_W-1:0]      x_dest;
        logic [PAYLOAD_SIZE-1:0] payload;
    } packet_t;

    localparam int         PKT_BYTES = ($bits(packet_t) + 7) / 8;
    localparam int         PKT_BITS  = PKT_BYTES * 8;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SOF  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        GAP  = 3'd4
    } link_state_t;

    // XOR of every byte of a zero-padded packet image; the receiver's checker
    // recomputes the check byte with this.
    function automatic logic [7:0] xor_fold(input logic [PKT_BITS-1:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < PKT_BYTES; i++) begin
            acc = acc ^ bytes[8*i +: 8];
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : link_tx_framer
//  Brief    : Serialises one packet per frame onto an 8-bit neighbour link:
//             SOF, packet bytes MSB-first, optional XOR check byte, idle gap.
//             Check byte enabled by defining LINK_TX_CHKSUM_EN.
//  Revision : 1.0
// ============================================================================
module link_tx_framer
    import noc_params::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter logic [7:0]  SOF_VALUE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  packet_t     pkt,
    output logic        ready,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        frame_done
);

    localparam int             BCW         = $clog2(PKT_BYTES + 1);
    localparam logic [BCW-1:0] c_last_byte = BCW'(PKT_BYTES - 1);
    localparam logic [3:0]     c_gap_last  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam link_state_t    c_after_frame = (GAP_CYCLES == 0) ? IDLE : GAP;

    link_state_t         r_state;
    link_state_t         w_next_state;
    logic [PKT_BITS-1:0] r_shift;
    logic [BCW-1:0]      r_byte_cnt;
    logic [BCW-1:0]      w_byte_cnt_next;
    logic [3:0]          r_gap_cnt;
    logic [7:0]          w_tx_next;
    logic                w_done_next;
    logic                w_accept;
`ifdef LINK_TX_CHKSUM_EN
    logic [7:0]          r_xor;
`endif

    assign ready    = (r_state == IDLE);
    assign w_accept = (r_state == IDLE) && valid_in;

    always_comb begin
        w_next_state    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_next_state = SOF;
                end
            end
            SOF: begin
                w_next_state    = DATA;
                w_byte_cnt_next = '0;
            end
            DATA: begin
                if (r_byte_cnt == c_last_byte) begin
`ifdef LINK_TX_CHKSUM_EN
                    w_next_state = CHK;
`else
                    w_next_state = c_after_frame;
`endif
                end else begin
                    w_byte_cnt_next = r_byte_cnt + 1'b1;
                end
            end
`ifdef LINK_TX_CHKSUM_EN
            CHK: begin
                w_next_state = c_after_frame;
            end
`endif
            GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Link byte and frame_done are registered, so they are derived from the
    // state being entered rather than the current one.
    always_comb begin
        w_tx_next   = IDLE_BYTE;
        w_done_next = 1'b0;
        case (w_next_state)
            SOF: begin
                w_tx_next = SOF_VALUE;
            end
            DATA: begin
                w_tx_next = r_shift[PKT_BITS-1 -: 8];
`ifndef LINK_TX_CHKSUM_EN
                w_done_next = (w_byte_cnt_next == c_last_byte);
`endif
            end
`ifdef LINK_TX_CHKSUM_EN
            CHK: begin
                w_tx_next   = r_xor;
                w_done_next = 1'b1;
            end
`endif
            default: begin
                w_tx_next = IDLE_BYTE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_gap_cnt  <= 4'd0;
            tx_byte    <= IDLE_BYTE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_byte_cnt <= w_byte_cnt_next;
            tx_byte    <= w_tx_next;
            busy       <= (w_next_state != IDLE);
            frame_done <= w_done_next;
            if (w_accept) begin
                r_shift <= PKT_BITS'(pkt);
            end else if (w_next_state == DATA) begin
                r_shift <= r_shift << 8;
            end
            if (w_next_state == GAP) begin
                r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 4'd1 : 4'd0;
            end
        end
    end

`ifdef LINK_TX_CHKSUM_EN
    // Running check: folds in each data byte as it is loaded onto the link.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xor <= 8'h00;
        end else if (w_accept) begin
            r_xor <= 8'h00;
        end else if (w_next_state == DATA) begin
            r_xor <= r_xor ^ r_shift[PKT_BITS-1 -: 8];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_link_tx_framer
//  Brief    : Self-checking bench for link_tx_framer (GAP_CYCLES=1 and 0).
//  Revision : 1.0
// ============================================================================
module tb_link_tx_framer;
    import noc_params::*;

    localparam int GAP_A = 1;
    localparam int GAP_B = 0;
    localparam int PW    = $bits(packet_t);
`ifdef LINK_TX_CHKSUM_EN
    localparam int F = PKT_BYTES + 2;
`else
    localparam int F = PKT_BYTES + 1;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0] b;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_s   [2];
    logic       valid_s [2];
    packet_t    pkt_s   [2];
    logic       ready_o [2];
    logic [7:0] tx_o    [2];
    logic       busy_o  [2];
    logic       done_o  [2];

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t mq [2][$];

    always #5 clk = ~clk;

    link_tx_framer #(.GAP_CYCLES(GAP_A), .SOF_VALUE(8'hA5)) dut_a (
        .clk(clk), .rst(rst_s[0]), .valid_in(valid_s[0]), .pkt(pkt_s[0]),
        .ready(ready_o[0]), .tx_byte(tx_o[0]), .busy(busy_o[0]), .frame_done(done_o[0])
    );

    link_tx_framer #(.GAP_CYCLES(GAP_B), .SOF_VALUE(8'hA5)) dut_b (
        .clk(clk), .rst(rst_s[1]), .valid_in(valid_s[1]), .pkt(pkt_s[1]),
        .ready(ready_o[1]), .tx_byte(tx_o[1]), .busy(busy_o[1]), .frame_done(done_o[1])
    );

    // Wire image of one frame: SOF, bytes MSB-first, optional XOR of data bytes.
    function automatic bq_t frame_of(input logic [PKT_BITS-1:0] p);
        bq_t        f;
        logic [7:0] c;
        c = 8'h00;
        f.push_back(8'hA5);
        for (int i = 0; i < PKT_BYTES; i++) begin
            f.push_back(p[8*(PKT_BYTES-1-i) +: 8]);
            c = c ^ p[8*(PKT_BYTES-1-i) +: 8];
        end
`ifdef LINK_TX_CHKSUM_EN
        f.push_back(c);
`endif
        return f;
    endfunction

    // Cycle-level reference: a queue of expected busy cycles per DUT; an empty
    // queue means the link is idle and ready.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                bq_t  fr;
                logic idle;
                idle = (mq[k].size() == 0);
                if (idle) begin
                    e.b    = 8'h00;
                    e.done = 1'b0;
                end else begin
                    e = mq[k][0];
                end
                checks++;
                if (tx_o[k] !== e.b || busy_o[k] !== !idle || ready_o[k] !== idle || done_o[k] !== e.done) begin
                    errors++;
                    $display("FAIL monitor dut%0d t=%0t got tx=%h busy=%b ready=%b done=%b want tx=%h busy=%b ready=%b done=%b",
                             k, $time, tx_o[k], busy_o[k], ready_o[k], done_o[k], e.b, !idle, idle, e.done);
                end
                if (!idle) begin
                    void'(mq[k].pop_front());
                end
                if (rst_s[k]) begin
                    mq[k].delete();
                end else if (idle && valid_s[k]) begin
                    fr = frame_of(PKT_BITS'(pkt_s[k]));
                    foreach (fr[i]) begin
                        e.b    = fr[i];
                        e.done = (i == fr.size() - 1);
                        mq[k].push_back(e);
                    end
                    for (int g = 0; g < ((k == 0) ? GAP_A : GAP_B); g++) begin
                        e.b    = 8'h00;
                        e.done = 1'b0;
                        mq[k].push_back(e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            rst_s[k]   = 1'b1;
            valid_s[k] = 1'b0;
            pkt_s[k]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        mon_en   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (tx_o[k] !== 8'h00 || busy_o[k] !== 1'b0 || ready_o[k] !== 1'b1 || done_o[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d got tx=%h busy=%b ready=%b done=%b want tx=00 busy=0 ready=1 done=0",
                             k, tx_o[k], busy_o[k], ready_o[k], done_o[k]);
                end
            end
        end
    endtask

    task automatic test_basic();
        bq_t        want;
        logic [7:0] eb;
`ifdef LINK_TX_CHKSUM_EN
        want = '{8'hA5, 8'h12, 8'h34, 8'h26};
`else
        want = '{8'hA5, 8'h12, 8'h34};
`endif
        @(posedge clk); #1;
        valid_s[0] = 1'b1;
        pkt_s[0]   = PW'(16'h1234);
        @(posedge clk); #1;
        valid_s[0] = 1'b0;
        for (int n = 1; n <= F + GAP_A + 1; n++) begin
            @(negedge clk);
            if (n <= F) eb = want[n-1];
            else        eb = 8'h00;
            checks++;
            if (tx_o[0] !== eb || done_o[0] !== (n == F) || ready_o[0] !== (n == F + GAP_A + 1)) begin
                errors++;
                $display("FAIL basic_1234 cycle t0+%0d got tx=%h done=%b ready=%b want tx=%h done=%b ready=%b",
                         n, tx_o[0], done_o[0], ready_o[0], eb, (n == F), (n == F + GAP_A + 1));
            end
        end
    endtask

    task automatic test_hold();
        bq_t want;
        bq_t tmp;
        want = frame_of(PKT_BITS'(16'h1234));
        for (int g = 0; g < GAP_A + 1; g++) want.push_back(8'h00);
        tmp = frame_of(PKT_BITS'(16'hBEEF));
        foreach (tmp[i]) want.push_back(tmp[i]);
        @(posedge clk); #1;
        valid_s[0] = 1'b1;
        pkt_s[0]   = PW'(16'h1234);
        @(posedge clk); #1;
        pkt_s[0]   = PW'(16'hBEEF);
        for (int n = 1; n <= want.size(); n++) begin
            @(negedge clk);
            checks++;
            if (tx_o[0] !== want[n-1]) begin
                errors++;
                $display("FAIL hold_valid cycle t0+%0d got tx=%h want tx=%h", n, tx_o[0], want[n-1]);
            end
            if (n == F + GAP_A + 1) begin
                @(posedge clk); #1;
                valid_s[0] = 1'b0;
            end
        end
        repeat (GAP_A + 3) @(posedge clk);
    endtask

    task automatic test_sof_data();
        bq_t want;
`ifdef LINK_TX_CHKSUM_EN
        want = '{8'hA5, 8'hA5, 8'h00, 8'hA5};
`else
        want = '{8'hA5, 8'hA5, 8'h00};
`endif
        @(posedge clk); #1;
        valid_s[0] = 1'b1;
        pkt_s[0]   = PW'(16'hA500);
        @(posedge clk); #1;
        valid_s[0] = 1'b0;
        for (int n = 1; n <= F; n++) begin
            @(negedge clk);
            checks++;
            if (tx_o[0] !== want[n-1] || busy_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL sof_in_data cycle t0+%0d got tx=%h busy=%b want tx=%h busy=1",
                         n, tx_o[0], busy_o[0], want[n-1]);
            end
        end
        repeat (GAP_A + 3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bq_t     want;
        packet_t p2;
        p2   = PW'($urandom);
        want = frame_of(PKT_BITS'(p2));
        @(posedge clk); #1;
        valid_s[0] = 1'b1;
        pkt_s[0]   = PW'($urandom);
        @(posedge clk); #1;
        valid_s[0] = 1'b0;
        @(posedge clk); #1;
        rst_s[0] = 1'b1;
        @(posedge clk); #1;
        rst_s[0]   = 1'b0;
        valid_s[0] = 1'b1;
        pkt_s[0]   = p2;
        @(negedge clk);
        checks++;
        if (tx_o[0] !== 8'h00 || ready_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got tx=%h ready=%b busy=%b want tx=00 ready=1 busy=0",
                     tx_o[0], ready_o[0], busy_o[0]);
        end
        @(posedge clk); #1;
        valid_s[0] = 1'b0;
        for (int n = 1; n <= F; n++) begin
            @(negedge clk);
            checks++;
            if (tx_o[0] !== want[n-1]) begin
                errors++;
                $display("FAIL reset_mid_refrm cycle %0d got tx=%h want tx=%h", n, tx_o[0], want[n-1]);
            end
        end
        repeat (GAP_A + 3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        bq_t want;
        bq_t tmp;
        want = frame_of(PKT_BITS'(16'h0001));
        for (int g = 0; g < GAP_B + 1; g++) want.push_back(8'h00);
        tmp = frame_of(PKT_BITS'(16'h0002));
        foreach (tmp[i]) want.push_back(tmp[i]);
        @(posedge clk); #1;
        valid_s[1] = 1'b1;
        pkt_s[1]   = PW'(16'h0001);
        @(posedge clk); #1;
        pkt_s[1]   = PW'(16'h0002);
        for (int n = 1; n <= want.size(); n++) begin
            @(negedge clk);
            checks++;
            if (tx_o[1] !== want[n-1]) begin
                errors++;
                $display("FAIL gap0_b2b cycle t0+%0d got tx=%h want tx=%h", n, tx_o[1], want[n-1]);
            end
            if (n == F + GAP_B + 1) begin
                @(posedge clk); #1;
                valid_s[1] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        repeat (400) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                rst_s[k]   = ($urandom_range(0, 49) == 0);
                valid_s[k] = ($urandom_range(0, 2) != 0);
                pkt_s[k]   = PW'($urandom);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            rst_s[k]   = 1'b0;
            valid_s[k] = 1'b0;
        end
        repeat (F + GAP_A + 3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_sof_data();
        test_reset_mid();
        test_back_to_back();
        test_random();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
